// File: rtl/conditioner_pkg.sv
// Shared definitions for the pushbutton/switch front end that feeds MSD.
package conditioner_pkg;

    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int NUM_BTN          = 3;

    typedef enum logic [1:0] {
        BTN_START = 2'd0,
        BTN_LOAD  = 2'd1,
        BTN_SEL   = 2'd2
    } btn_e;

endpackage

// File: rtl/debounce_cell.sv
// One pushbutton: 2-flop synchronizer, debounce counter, stable level and
// a single-cycle pulse on each accepted press (stable 0->1).
module debounce_cell
    import conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1, sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          accept;

    // The mismatch has lasted DEBOUNCE_CYCLES edges, counting this one.
    assign accept = (sync2 != stable) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            stable      <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= ~raw_n;
            sync2       <= sync1;
            press_pulse <= accept & sync2;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign level = stable;

endmodule

// File: rtl/input_conditioner.sv
// Board front end: debounced start/load pulses, debounced select level and
// synchronized operand switches for MSD.
module input_conditioner
    import conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int WORD_LENGHT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_n,
    input  logic                   load_n,
    input  logic                   sel_n,
    input  logic [WORD_LENGHT-1:0] data_raw,
    output logic                   start_pulse,
    output logic                   load_pulse,
    output logic                   sel_level,
    output logic [WORD_LENGHT-1:0] data_sync
);

    logic [NUM_BTN-1:0]     raw_n;
    logic [NUM_BTN-1:0]     level;
    logic [NUM_BTN-1:0]     pulse;
    logic [WORD_LENGHT-1:0] data_meta;
    logic                   unused_bits;

    assign raw_n[BTN_START] = start_n;
    assign raw_n[BTN_LOAD]  = load_n;
    assign raw_n[BTN_SEL]   = sel_n;

    debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NUM_BTN-1:0] (
        .clk         (clk),
        .rst         (rst),
        .raw_n       (raw_n),
        .level       (level),
        .press_pulse (pulse)
    );

    assign start_pulse = pulse[BTN_START];
    assign load_pulse  = pulse[BTN_LOAD];
    assign sel_level   = level[BTN_SEL];

    // Start/load are only consumed as pulses, select only as a level.
    assign unused_bits = ^{level[BTN_START], level[BTN_LOAD], pulse[BTN_SEL]};

    // Switches are settled long before load is accepted, so no debounce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_meta <= '0;
            data_sync <= '0;
        end else begin
            data_meta <= data_raw;
            data_sync <= data_meta;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios plus randomized button/switch activity, checked every
// cycle against a window-based behavioural model of the conditioner.
module tb_input_conditioner;

    localparam int D = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_n, load_n, sel_n;
    logic [W-1:0] data_raw;
    logic         start_pulse, load_pulse, sel_level;
    logic [W-1:0] data_sync;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .WORD_LENGHT(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_n     (start_n),
        .load_n      (load_n),
        .sel_n       (sel_n),
        .data_raw    (data_raw),
        .start_pulse (start_pulse),
        .load_pulse  (load_pulse),
        .sel_level   (sel_level),
        .data_sync   (data_sync)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Model: a button's accepted level flips once its synchronized value has
    // disagreed with that level on each of the last D edges.
    logic [2:0]   m_s1, m_s2, m_stable, m_pulse;
    logic [D-1:0] m_hist [3];
    logic [W-1:0] m_d1, m_d2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 <= '0; m_s2 <= '0; m_stable <= '0; m_pulse <= '0;
            m_d1 <= '0; m_d2 <= '0;
            for (int b = 0; b < 3; b++) m_hist[b] <= '0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                m_hist[b] <= {m_hist[b][D-2:0], m_s2[b]};
                if ({m_hist[b][D-2:0], m_s2[b]} == {D{~m_stable[b]}}) begin
                    m_stable[b] <= ~m_stable[b];
                    m_pulse[b]  <= ~m_stable[b];
                end else begin
                    m_pulse[b] <= 1'b0;
                end
            end
            m_s2 <= m_s1;
            m_s1 <= ~{sel_n, load_n, start_n};
            m_d2 <= m_d1;
            m_d1 <= data_raw;
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({start_pulse, load_pulse, sel_level} !== {m_pulse[0], m_pulse[1], m_stable[2]}) begin
            errors++;
            $display("FAIL model_buttons edge %0d: got start/load/sel=%b%b%b want %b%b%b",
                     edge_n, start_pulse, load_pulse, sel_level, m_pulse[0], m_pulse[1], m_stable[2]);
        end
        checks++;
        if (data_sync !== m_d2) begin
            errors++;
            $display("FAIL model_data edge %0d: got %h want %h", edge_n, data_sync, m_d2);
        end
    end

    // Event monitor for the hand-computed expectations.
    int           n_start = 0, n_load = 0, last_start = -1, last_load = -1;
    int           sel_rise = -1, sel_fall = -1;
    logic         sel_prev = 1'b0;
    logic [W-1:0] data_at_load = '0;

    always @(negedge clk) begin
        if (start_pulse) begin n_start++; last_start = edge_n; end
        if (load_pulse)  begin n_load++;  last_load = edge_n; data_at_load = data_sync; end
        if (sel_level && !sel_prev) sel_rise = edge_n;
        if (!sel_level && sel_prev) sel_fall = edge_n;
        sel_prev = sel_level;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int k, r, s0, l0;

    initial begin
        rst = 1'b0; start_n = 1'b1; load_n = 1'b1; sel_n = 1'b1; data_raw = '0;

        // Reset held with inputs toggling: everything stays at zero.
        for (int i = 0; i < 10; i++) begin
            {start_n, load_n, sel_n} = 3'($urandom);
            data_raw = W'($urandom);
            step(1);
            #1;
            check("reset_outputs", int'({start_pulse, load_pulse, sel_level}), 0);
            check("reset_data", int'(data_sync), 0);
        end
        start_n = 1'b1; load_n = 1'b1; sel_n = 1'b1;
        rst = 1'b1;
        step(50);
        check("post_reset_no_pulse", n_start + n_load, 0);
        check("post_reset_no_sel", sel_rise, -1);

        // Clean press held for 20 cycles.
        start_n = 1'b0; k = edge_n + 1; s0 = n_start;
        step(20);
        start_n = 1'b1;
        step(15);
        check("clean_press_count", n_start - s0, 1);
        check("clean_press_edge", last_start, k + 5);

        // Bounce: 3 low, 1 high, 10 low.
        load_n = 1'b0; k = edge_n + 1; l0 = n_load;
        step(3); load_n = 1'b1;
        step(1); load_n = 1'b0;
        step(10); load_n = 1'b1;
        step(15);
        check("bounce_count", n_load - l0, 1);
        check("bounce_edge", last_load, k + 9);

        // Select level follows the debounced button both ways.
        sel_n = 1'b0; k = edge_n + 1;
        step(10); sel_n = 1'b1;
        step(15);
        check("sel_rise_edge", sel_rise, k + 5);
        check("sel_fall_edge", sel_fall, k + 15);

        // Simultaneous start/load with operand switches set beforehand.
        data_raw = 16'hA5C3;
        step(20);
        start_n = 1'b0; load_n = 1'b0; k = edge_n + 1; s0 = n_start; l0 = n_load;
        step(20);
        start_n = 1'b1; load_n = 1'b1;
        step(15);
        check("simul_start_count", n_start - s0, 1);
        check("simul_load_count", n_load - l0, 1);
        check("simul_start_edge", last_start, k + 5);
        check("simul_load_edge", last_load, k + 5);
        check("simul_data", int'(data_at_load), 16'hA5C3);

        // Reset mid-count with the button still held.
        start_n = 1'b0; k = edge_n + 1; s0 = n_start;
        step(2); rst = 1'b0;
        step(1); rst = 1'b1; r = edge_n + 1;
        step(20);
        start_n = 1'b1;
        step(15);
        check("reset_mid_count", n_start - s0, 1);
        check("reset_mid_edge", last_start, r + 5);

        // Randomized bouncing buttons, switch changes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(4) == 0) start_n = ~start_n;
            if ($urandom_range(4) == 0) load_n  = ~load_n;
            if ($urandom_range(5) == 0) sel_n   = ~sel_n;
            if ($urandom_range(49) == 0) data_raw = W'($urandom);
            rst = ($urandom_range(799) != 0);
            step(1);
        end
        rst = 1'b1;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that sits between the board pushbuttons/switches and the arithmetic core (MSD). It synchronizes and debounces the three active-low pushbuttons. It converts `start` and `load` presses into clean single-cycle active-high pulses, and provides a debounced level for the result/residue select. It also double-registers the 16 operand switches so MSD sees metastability-free data aligned with the load pulse.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000 (10 ms at 50 MHz): consecutive stable cycles required to accept a button change. Legal range is ≥ 2.
- `WORD_LENGHT`, default 16: operand switch width.

Ports:
- `clk`  in  1  system clock; the block has a single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start_n`  in  1  raw start pushbutton, 0 = pressed.
- `load_n`  in  1  raw load pushbutton, 0 = pressed.
- `sel_n`  in  1  raw result/residue select pushbutton, 0 = pressed.
- `data_raw`  in  WORD_LENGHT  raw operand switches.
- `start_pulse`  out  1  one-cycle pulse per accepted start press.
- `load_pulse`  out  1  one-cycle pulse per accepted load press.
- `sel_level`  out  1  debounced select, 1 = pressed (selects residue).
- `data_sync`  out  WORD_LENGHT  switches after a 2-flop synchronizer.

## Operation
- Each button goes through an identical path: 2-flop synchronizer, then debounce counter, then stable-state register, then press detector.
- Internally every button is inverted to active-high: `sync = ~raw` after 2 flops.
- Debounce, per button, evaluated at each clock edge:
  - If `sync == stable`: counter ← 0.
  - If `sync != stable` and counter < DEBOUNCE_CYCLES−1: counter ← counter+1.
  - If `sync != stable` and counter == DEBOUNCE_CYCLES−1: stable ← sync, counter ← 0.
- Press detector: the pulse register is set to 1 at the edge where stable changes 0→1. It is 0 at every other edge.
  - A release (1→0) produces no pulse.
  - Each press yields exactly one pulse, regardless of hold time.
- `sel_level` = stable state of the select button. `start_pulse` and `load_pulse` = pulse registers of their buttons.
- Buttons are fully independent. Simultaneous presses each produce their own pulse, in the same cycle if their timing aligns.
- Glitches: any mismatch run shorter than DEBOUNCE_CYCLES cycles resets the counter and leaves stable unchanged. No pulse is produced.
- `data_sync` is a plain 2-flop synchronizer on every bit. It is not debounced; switches are assumed settled before `load` is pressed.
- Counter width = $clog2(DEBOUNCE_CYCLES).

## Timing
- Reset values (`rst` low, asynchronous):
  - Synchronizer flops = released (internal 0).
  - Counters = 0, stable = 0.
  - `start_pulse` = 0, `load_pulse` = 0, `sel_level` = 0, `data_sync` = 0.
- Button path: raw changes and is captured at edge k; sync reflects it after edge k+1. If the raw level holds, stable updates at edge k+1+DEBOUNCE_CYCLES. A press pulse is high for exactly the one cycle following that edge.
- `data_sync` latency: 2 cycles.
- A button held through reset deassertion is seen as a new press. It pulses DEBOUNCE_CYCLES+2 edges after release of reset; this is intended.
- Reset asserted mid-count aborts the count and any pending pulse immediately.
- `data_sync` is stable for ≥ DEBOUNCE_CYCLES cycles before `load_pulse` whenever switches are static. MSD samples data on `load_pulse`.

## Structure
- Shared package `conditioner_pkg`:
  - `localparam DEBOUNCE_DEFAULT = 500000`.
  - Button index enum `btn_e {BTN_START, BTN_LOAD, BTN_SEL}`.
- Sub-module `debounce_cell`: synchronizer, counter, stable register and press pulse for one button, with ports `clk`, `rst`, `raw_n`, `level`, `press_pulse`. It is instantiated three times.
- Top of block: three `debounce_cell` instances plus the data synchronizer.
- Downstream, MSD consumes `start_pulse` and `load_pulse` directly, and `sel_level` drives the result/residue mux select without inversion.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: hold `rst` = 0 with all inputs toggling. All outputs read 0. Release `rst` with buttons released: no pulse for 50 cycles.
- Clean press: `start_n` goes low at edge 10 and stays low for 20 cycles. `start_pulse` is high only in the cycle after edge 15; no second pulse while held; no pulse on release.
- Bounce: `load_n` goes low for 3 cycles, high for 1, then low for 10. Exactly one `load_pulse`, occurring 5 edges after the final falling sample. The 3-cycle glitch alone produces none.
- Select level: `sel_n` goes low for 10 cycles, then high. `sel_level` rises 5 edges after the low is sampled and falls 5 edges after the high is sampled.
- Simultaneous events: `start_n` and `load_n` fall at the same edge. Both pulses are high in the same single cycle. With `data_raw` = 16'hA5C3 applied 20 cycles earlier, `data_sync` = 16'hA5C3 at the pulse.
- Reset mid-operation: `start_n` goes low and `rst` pulses low 2 cycles later. No `start_pulse` appears during reset. One pulse appears 6 edges after reset release, since the button is still held.
